mole_game_core: RTL



---
 rtl/mole_game_if.sv | 34 +++
 rtl/mole_game_core.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mole_game_if.sv
// Signal bundle between the whack-a-mole engine and its strobe sources and display sinks.
// Inputs are single-cycle strobes, sampled on the rising clock edge with no backpressure.
// Every output is registered, and hit_event/miss_event are one-cycle pulses.
interface mole_game_if #(
  parameter int NUM_MOLES   = 5,
  parameter int SCORE_WIDTH = 6,
  parameter int TIME_W      = 5
);
  logic                   start_pulse;
  logic                   sec_pulse;
  logic                   step_pulse;
  logic [NUM_MOLES-1:0]   hit_pulse;
  logic [NUM_MOLES-1:0]   mole_led;
  logic [SCORE_WIDTH-1:0] score;
  logic [SCORE_WIDTH-1:0] misses;
  logic [TIME_W-1:0]      time_left;
  logic                   game_active;
  logic                   game_over;
  logic                   hit_event;
  logic                   miss_event;
  logic [2:0]             state_dbg;

  modport master (
    output start_pulse, sec_pulse, step_pulse, hit_pulse,
    input  mole_led, score, misses, time_left, game_active, game_over,
           hit_event, miss_event, state_dbg
  );

  modport slave (
    input  start_pulse, sec_pulse, step_pulse, hit_pulse,
    output mole_led, score, misses, time_left, game_active, game_over,
           hit_event, miss_event, state_dbg
  );
endinterface

// File: rtl/mole_game_core.sv
// Whack-a-mole engine with a game timer, mole lifetime that shrinks as hits accumulate,
// LFSR-based mole placement, and saturating hit/miss counters.
module mole_game_core #(
  parameter int          NUM_MOLES       = 5,
  parameter int          SCORE_WIDTH     = 6,
  parameter int          GAME_SECONDS    = 30,
  parameter int          MOLE_STEPS_INIT = 20,
  parameter int          MOLE_STEPS_MIN  = 5,
  parameter int          GAP_STEPS       = 3,
  parameter int          SPEEDUP_EVERY   = 5,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input logic        clock,
  input logic        reset,
  mole_game_if.slave bus
);
  localparam int TIME_W = $clog2(GAME_SECONDS + 1);
  localparam int IDX_W  = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam int STEP_W = $clog2(MOLE_STEPS_INIT + 1);
  localparam int GAP_W  = $clog2(GAP_STEPS + 1);
  localparam int DIV_W  = $clog2(SPEEDUP_EVERY + 1);

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_SHOW, S_GAP, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [15:0]            lfsr, lfsr_nxt;
  logic [NUM_MOLES-1:0]   mole_r, mole_nxt;
  logic [SCORE_WIDTH-1:0] score_r, score_nxt, misses_r, misses_nxt;
  logic [TIME_W-1:0]      time_r, time_nxt;
  logic                   active_r, active_nxt, over_r, over_nxt;
  logic                   hev_r, hev_nxt, mev_r, mev_nxt;
  logic [STEP_W-1:0]      life_r, life_nxt, step_r, step_nxt;
  logic [GAP_W-1:0]       gap_r, gap_nxt;
  logic [DIV_W-1:0]       div_r, div_nxt;
  logic [IDX_W-1:0]       prev_r, prev_nxt;

  logic [IDX_W-1:0]       raw_idx, spawn_idx;
  logic                   correct_hit, wrong_hit;

  assign raw_idx   = IDX_W'(lfsr % 16'(NUM_MOLES));
  // Never light the same hole twice in a row, so a new mole is always visibly new.
  assign spawn_idx = (raw_idx != prev_r) ? raw_idx :
                     (raw_idx == IDX_W'(NUM_MOLES - 1)) ? '0 : raw_idx + IDX_W'(1);

  assign correct_hit = |(bus.hit_pulse & mole_r);
  assign wrong_hit   = |(bus.hit_pulse & ~mole_r);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      lfsr     <= LFSR_SEED;
      mole_r   <= '0;
      score_r  <= '0;
      misses_r <= '0;
      time_r   <= TIME_W'(GAME_SECONDS);
      active_r <= 1'b0;
      over_r   <= 1'b0;
      hev_r    <= 1'b0;
      mev_r    <= 1'b0;
      life_r   <= STEP_W'(MOLE_STEPS_INIT);
      step_r   <= '0;
      gap_r    <= '0;
      div_r    <= '0;
      prev_r   <= IDX_W'(NUM_MOLES - 1);
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_nxt;
      mole_r   <= mole_nxt;
      score_r  <= score_nxt;
      misses_r <= misses_nxt;
      time_r   <= time_nxt;
      active_r <= active_nxt;
      over_r   <= over_nxt;
      hev_r    <= hev_nxt;
      mev_r    <= mev_nxt;
      life_r   <= life_nxt;
      step_r   <= step_nxt;
      gap_r    <= gap_nxt;
      div_r    <= div_nxt;
      prev_r   <= prev_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    // The LFSR free-runs in every state so the player's start timing seeds placement.
    lfsr_nxt   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    mole_nxt   = mole_r;
    score_nxt  = score_r;
    misses_nxt = misses_r;
    time_nxt   = time_r;
    active_nxt = active_r;
    over_nxt   = over_r;
    hev_nxt    = 1'b0;
    mev_nxt    = 1'b0;
    life_nxt   = life_r;
    step_nxt   = step_r;
    gap_nxt    = gap_r;
    div_nxt    = div_r;
    prev_nxt   = prev_r;

    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start_pulse) begin
          score_nxt  = '0;
          misses_nxt = '0;
          time_nxt   = TIME_W'(GAME_SECONDS);
          life_nxt   = STEP_W'(MOLE_STEPS_INIT);
          div_nxt    = '0;
          over_nxt   = 1'b0;
          active_nxt = 1'b1;
          state_nxt  = S_SPAWN;
        end
      end
      S_SPAWN, S_SHOW, S_GAP: begin
        if (bus.sec_pulse) time_nxt = time_r - TIME_W'(1);
        // Timer expiry overrides any hit or miss arriving in the same cycle.
        if (bus.sec_pulse && time_r == TIME_W'(1)) begin
          mole_nxt   = '0;
          active_nxt = 1'b0;
          over_nxt   = 1'b1;
          state_nxt  = S_DONE;
        end else if (state == S_SPAWN) begin
          mole_nxt  = NUM_MOLES'(1) << spawn_idx;
          prev_nxt  = spawn_idx;
          step_nxt  = life_r;
          state_nxt = S_SHOW;
        end else if (state == S_SHOW) begin
          if (correct_hit) begin
            score_nxt = (score_r == '1) ? score_r : score_r + SCORE_WIDTH'(1);
            hev_nxt   = 1'b1;
            mole_nxt  = '0;
            gap_nxt   = GAP_W'(GAP_STEPS);
            state_nxt = S_GAP;
            if (div_r == DIV_W'(SPEEDUP_EVERY - 1)) begin
              div_nxt = '0;
              if (life_r > STEP_W'(MOLE_STEPS_MIN)) life_nxt = life_r - STEP_W'(1);
            end else begin
              div_nxt = div_r + DIV_W'(1);
            end
          end else if (bus.step_pulse && step_r == STEP_W'(1)) begin
            misses_nxt = (misses_r == '1) ? misses_r : misses_r + SCORE_WIDTH'(1);
            mev_nxt    = 1'b1;
            mole_nxt   = '0;
            gap_nxt    = GAP_W'(GAP_STEPS);
            state_nxt  = S_GAP;
          end else begin
            if (wrong_hit) begin
              misses_nxt = (misses_r == '1) ? misses_r : misses_r + SCORE_WIDTH'(1);
              mev_nxt    = 1'b1;
            end
            if (bus.step_pulse) step_nxt = step_r - STEP_W'(1);
          end
        end else if (bus.step_pulse) begin
          if (gap_r == GAP_W'(1)) state_nxt = S_SPAWN;
          else gap_nxt = gap_r - GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.mole_led    = mole_r;
  assign bus.score       = score_r;
  assign bus.misses      = misses_r;
  assign bus.time_left   = time_r;
  assign bus.game_active = active_r;
  assign bus.game_over   = over_r;
  assign bus.hit_event   = hev_r;
  assign bus.miss_event  = mev_r;
  assign bus.state_dbg   = state;
endmodule
